// File: rtl/uni_axi_bridge.sv
// uni_axi_bridge: converts a single-request "uni" slave port into single-beat
// AXI4 read/write transactions, one outstanding at a time.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   uni slave             i_valid/o_ready handshake, i_reqtyp (0 rd, 1 wr),
//                         i_addr, i_wdata, o_rdata, i_cachable, i_size
//   AXI4 AW/W/B           write address, write data, write response
//   AXI4 AR/R             read address, read data
module uni_axi_bridge #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    parameter logic [3:0]  AXI_ID = 4'd0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    // uni slave port
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_reqtyp,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    input  logic              i_cachable,
    input  logic [1:0]        i_size,
    // AXI4 AW
    output logic              o_awvalid,
    input  logic              i_awready,
    output logic [ADDR_W-1:0] o_awaddr,
    output logic [3:0]        o_awid,
    output logic [7:0]        o_awlen,
    output logic [2:0]        o_awsize,
    output logic [1:0]        o_awburst,
    output logic [3:0]        o_awcache,
    // AXI4 W
    output logic              o_wvalid,
    input  logic              i_wready,
    output logic [DATA_W-1:0] o_wdata,
    output logic [7:0]        o_wstrb,
    output logic              o_wlast,
    // AXI4 B
    input  logic              i_bvalid,
    output logic              o_bready,
    input  logic [1:0]        i_bresp,
    // AXI4 AR
    output logic              o_arvalid,
    input  logic              i_arready,
    output logic [ADDR_W-1:0] o_araddr,
    output logic [3:0]        o_arid,
    output logic [7:0]        o_arlen,
    output logic [2:0]        o_arsize,
    output logic [1:0]        o_arburst,
    output logic [3:0]        o_arcache,
    // AXI4 R
    input  logic              i_rvalid,
    output logic              o_rready,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [1:0]        i_rresp,
    input  logic              i_rlast
);

    typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B, DONE} state_t;

    state_t              r_state;
    state_t              w_next;

    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [1:0]          r_size;
    logic                r_cachable;
    logic                r_reqtyp;
    logic [DATA_W-1:0]   r_rdata;

    logic                r_arvalid;
    logic                r_awvalid;
    logic                r_wvalid;
    logic                r_rready;
    logic                r_bready;
    logic                r_ready;

    logic                w_aw_done;
    logic                w_w_done;
    logic [5:0]          w_shamt;
    logic [7:0]          w_size_mask;
    logic                w_unused;

    // Responses carry no information this bridge acts on.
    assign w_unused = ^{i_bresp, i_rresp, i_rlast, r_reqtyp};

    // Byte lane offset within the 64-bit bus, in bits.
    assign w_shamt = {r_addr[2:0], 3'b000};

    // A write channel counts as done once its valid is already low or is
    // being accepted this cycle; AW and W may complete in either order.
    assign w_aw_done = !r_awvalid || i_awready;
    assign w_w_done  = !r_wvalid  || i_wready;

    always_comb begin
        w_size_mask = 8'hFF;
        case (r_size)
            2'b00:   w_size_mask = 8'h01;
            2'b01:   w_size_mask = 8'h03;
            2'b10:   w_size_mask = 8'h0F;
            default: w_size_mask = 8'hFF;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_valid)                w_next = i_reqtyp ? WR_AW : RD_A;
            RD_A:    if (i_arready)              w_next = RD_D;
            RD_D:    if (i_rvalid)               w_next = DONE;
            WR_AW:   if (w_aw_done && w_w_done)  w_next = WR_B;
            WR_B:    if (i_bvalid)               w_next = DONE;
            DONE:                                w_next = IDLE;
            default:                             w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_size     <= '0;
            r_cachable <= 1'b0;
            r_reqtyp   <= 1'b0;
            r_rdata    <= '0;
            r_arvalid  <= 1'b0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_rready   <= 1'b0;
            r_bready   <= 1'b0;
            r_ready    <= 1'b0;
        end else begin
            r_state  <= w_next;
            // Handshake outputs are flops decoded from the next state so that
            // they are glitch-free and never combinational on a ready input.
            r_arvalid <= (w_next == RD_A);
            r_rready  <= (w_next == RD_D);
            r_bready  <= (w_next == WR_B);
            r_ready   <= (w_next == DONE);

            if (r_state == IDLE && i_valid) begin
                r_addr     <= i_addr;
                r_wdata    <= i_wdata;
                r_size     <= i_size;
                r_cachable <= i_cachable;
                r_reqtyp   <= i_reqtyp;
                r_awvalid  <= i_reqtyp;
                r_wvalid   <= i_reqtyp;
            end else begin
                if (i_awready) r_awvalid <= 1'b0;
                if (i_wready)  r_wvalid  <= 1'b0;
            end

            if (r_state == RD_D && i_rvalid) begin
                r_rdata <= i_rdata >> w_shamt;
            end
        end
    end

    assign o_ready   = r_ready;
    assign o_rdata   = r_rdata;

    assign o_awvalid = r_awvalid;
    assign o_awaddr  = r_addr;
    assign o_awid    = AXI_ID;
    assign o_awlen   = 8'd0;
    assign o_awsize  = {1'b0, r_size};
    assign o_awburst = 2'b01;
    assign o_awcache = {4{r_cachable}};

    assign o_wvalid  = r_wvalid;
    assign o_wdata   = r_wdata << w_shamt;
    assign o_wstrb   = w_size_mask << r_addr[2:0];
    assign o_wlast   = 1'b1;

    assign o_bready  = r_bready;

    assign o_arvalid = r_arvalid;
    assign o_araddr  = r_addr;
    assign o_arid    = AXI_ID;
    assign o_arlen   = 8'd0;
    assign o_arsize  = {1'b0, r_size};
    assign o_arburst = 2'b01;
    assign o_arcache = {4{r_cachable}};

    assign o_rready  = r_rready;

endmodule

// File: tb/tb_uni_axi_bridge.sv
// tb_uni_axi_bridge: scenario tasks drive the uni port and AXI slave handshakes;
// a negedge monitor pops scoreboard entries on every AXI handshake and o_ready.
module tb_uni_axi_bridge;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic        i_reqtyp;
    logic [31:0] i_addr;
    logic [63:0] i_wdata;
    logic [63:0] o_rdata;
    logic        i_cachable;
    logic [1:0]  i_size;
    logic        o_awvalid, i_awready;
    logic [31:0] o_awaddr;
    logic [3:0]  o_awid;
    logic [7:0]  o_awlen;
    logic [2:0]  o_awsize;
    logic [1:0]  o_awburst;
    logic [3:0]  o_awcache;
    logic        o_wvalid, i_wready;
    logic [63:0] o_wdata;
    logic [7:0]  o_wstrb;
    logic        o_wlast;
    logic        i_bvalid, o_bready;
    logic [1:0]  i_bresp;
    logic        o_arvalid, i_arready;
    logic [31:0] o_araddr;
    logic [3:0]  o_arid;
    logic [7:0]  o_arlen;
    logic [2:0]  o_arsize;
    logic [1:0]  o_arburst;
    logic [3:0]  o_arcache;
    logic        i_rvalid, o_rready;
    logic [63:0] i_rdata;
    logic [1:0]  i_rresp;
    logic        i_rlast;

    logic [5:0]  ctl;
    assign ctl = {o_arvalid, o_awvalid, o_wvalid, o_rready, o_bready, o_ready};

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {logic [31:0] addr; logic [2:0] size; logic [3:0] cache;} a_t;
    typedef struct packed {logic [63:0] data; logic [7:0] strb;} w_t;
    typedef struct packed {logic rd; logic [63:0] data;} d_t;
    a_t q_ar[$];
    a_t q_aw[$];
    w_t q_w[$];
    d_t q_done[$];

    uni_axi_bridge #(.ADDR_W(32), .DATA_W(64), .AXI_ID(4'd0)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_valid(i_valid), .o_ready(o_ready), .i_reqtyp(i_reqtyp), .i_addr(i_addr),
        .i_wdata(i_wdata), .o_rdata(o_rdata), .i_cachable(i_cachable), .i_size(i_size),
        .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr), .o_awid(o_awid),
        .o_awlen(o_awlen), .o_awsize(o_awsize), .o_awburst(o_awburst), .o_awcache(o_awcache),
        .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata), .o_wstrb(o_wstrb),
        .o_wlast(o_wlast),
        .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp),
        .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr), .o_arid(o_arid),
        .o_arlen(o_arlen), .o_arsize(o_arsize), .o_arburst(o_arburst), .o_arcache(o_arcache),
        .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rdata(i_rdata), .i_rresp(i_rresp),
        .i_rlast(i_rlast)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    // Present a request and push what the bridge must produce for it.
    task automatic issue(input bit rd, input logic [31:0] addr, input logic [1:0] size,
                         input bit cach, input logic [63:0] wd, input logic [63:0] slave_rd);
        a_t a;
        w_t w;
        d_t d;
        logic [7:0] m;
        logic [5:0] sh;
        sh = {addr[2:0], 3'b000};
        case (size)
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            2'b10:   m = 8'h0F;
            default: m = 8'hFF;
        endcase
        a.addr  = addr;
        a.size  = {1'b0, size};
        a.cache = cach ? 4'hF : 4'h0;
        if (rd) begin
            q_ar.push_back(a);
        end else begin
            q_aw.push_back(a);
            w.data = wd << sh;
            w.strb = m << addr[2:0];
            q_w.push_back(w);
        end
        d.rd   = rd;
        d.data = slave_rd >> sh;
        q_done.push_back(d);
        i_valid    = 1'b1;
        i_reqtyp   = !rd;
        i_addr     = addr;
        i_size     = size;
        i_cachable = cach;
        i_wdata    = wd;
        i_rdata    = slave_rd;
    endtask

    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_arvalid && i_arready) begin
                n_tests++;
                if (q_ar.size() == 0) begin
                    n_fail++;
                    $display("FAIL ar_unexpected: araddr=%h with nothing outstanding", o_araddr);
                end else begin
                    a_t e;
                    e = q_ar.pop_front();
                    if ({o_araddr, o_arsize, o_arcache, o_arlen, o_arburst, o_arid} !==
                        {e.addr, e.size, e.cache, 8'd0, 2'b01, 4'd0}) begin
                        n_fail++;
                        $display("FAIL ar_fields: got addr=%h size=%0d cache=%h len=%0d burst=%b id=%0d, want addr=%h size=%0d cache=%h len=0 burst=01 id=0",
                                 o_araddr, o_arsize, o_arcache, o_arlen, o_arburst, o_arid, e.addr, e.size, e.cache);
                    end
                end
            end
            if (o_awvalid && i_awready) begin
                n_tests++;
                if (q_aw.size() == 0) begin
                    n_fail++;
                    $display("FAIL aw_unexpected: awaddr=%h with nothing outstanding", o_awaddr);
                end else begin
                    a_t e;
                    e = q_aw.pop_front();
                    if ({o_awaddr, o_awsize, o_awcache, o_awlen, o_awburst, o_awid} !==
                        {e.addr, e.size, e.cache, 8'd0, 2'b01, 4'd0}) begin
                        n_fail++;
                        $display("FAIL aw_fields: got addr=%h size=%0d cache=%h len=%0d burst=%b id=%0d, want addr=%h size=%0d cache=%h len=0 burst=01 id=0",
                                 o_awaddr, o_awsize, o_awcache, o_awlen, o_awburst, o_awid, e.addr, e.size, e.cache);
                    end
                end
            end
            if (o_wvalid && i_wready) begin
                n_tests++;
                if (q_w.size() == 0) begin
                    n_fail++;
                    $display("FAIL w_unexpected: wdata=%h with nothing outstanding", o_wdata);
                end else begin
                    w_t e;
                    e = q_w.pop_front();
                    if ({o_wdata, o_wstrb, o_wlast} !== {e.data, e.strb, 1'b1}) begin
                        n_fail++;
                        $display("FAIL w_fields: got data=%h strb=%h last=%b, want data=%h strb=%h last=1",
                                 o_wdata, o_wstrb, o_wlast, e.data, e.strb);
                    end
                end
            end
            if (o_ready) begin
                n_tests++;
                if (q_done.size() == 0) begin
                    n_fail++;
                    $display("FAIL ready_unexpected: o_ready=1 with nothing outstanding");
                end else begin
                    d_t e;
                    e = q_done.pop_front();
                    if (e.rd && o_rdata !== e.data) begin
                        n_fail++;
                        $display("FAIL rdata_sb: got %h, want %h", o_rdata, e.data);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (3) cyc();
        n_tests++;
        if (ctl !== 6'b000000 || o_rdata !== 64'd0 || o_araddr !== 32'd0 ||
            o_awaddr !== 32'd0 || o_wdata !== 64'd0 || o_arcache !== 4'd0 || o_arsize !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: ctl=%b rdata=%h araddr=%h awaddr=%h wdata=%h arcache=%h arsize=%0d, want all zero",
                     ctl, o_rdata, o_araddr, o_awaddr, o_wdata, o_arcache, o_arsize);
        end
        i_rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_read_dword();
        i_arready = 1'b1;
        i_rvalid  = 1'b1;
        issue(1'b1, 32'h8000_0008, 2'b11, 1'b1, 64'd0, 64'h1122334455667788);
        cyc();
        i_valid = 1'b0;
        n_tests++;
        if (ctl !== 6'b100000 || o_araddr !== 32'h8000_0008 || o_arsize !== 3'd3) begin
            n_fail++;
            $display("FAIL rd_dword_ar: ctl=%b addr=%h size=%0d, want ctl=100000 addr=80000008 size=3", ctl, o_araddr, o_arsize);
        end
        cyc();
        n_tests++;
        if (ctl !== 6'b000100) begin
            n_fail++;
            $display("FAIL rd_dword_r: ctl=%b, want 000100", ctl);
        end
        cyc();
        n_tests++;
        if (ctl !== 6'b000001 || o_rdata !== 64'h1122334455667788) begin
            n_fail++;
            $display("FAIL rd_dword_done: ctl=%b rdata=%h, want ctl=000001 rdata=1122334455667788", ctl, o_rdata);
        end
        cyc();
        n_tests++;
        if (ctl !== 6'b000000) begin
            n_fail++;
            $display("FAIL rd_dword_idle: ctl=%b, want 000000", ctl);
        end
        i_arready = 1'b0;
        i_rvalid  = 1'b0;
    endtask

    task automatic test_write_byte();
        i_awready = 1'b1;
        i_wready  = 1'b1;
        i_bvalid  = 1'b1;
        issue(1'b0, 32'h8000_0005, 2'b00, 1'b1, 64'hAB, 64'd0);
        cyc();
        i_valid = 1'b0;
        n_tests++;
        if (ctl !== 6'b011000 || o_wstrb !== 8'h20 || o_wdata !== 64'h0000_AB00_0000_0000 ||
            o_awsize !== 3'd0 || o_awcache !== 4'hF || o_wlast !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_byte_aw: ctl=%b strb=%h wdata=%h awsize=%0d cache=%h wlast=%b, want 011000 20 0000ab0000000000 0 f 1",
                     ctl, o_wstrb, o_wdata, o_awsize, o_awcache, o_wlast);
        end
        cyc();
        n_tests++;
        if (ctl !== 6'b000010) begin
            n_fail++;
            $display("FAIL wr_byte_b: ctl=%b, want 000010", ctl);
        end
        cyc();
        n_tests++;
        if (ctl !== 6'b000001) begin
            n_fail++;
            $display("FAIL wr_byte_done: ctl=%b, want 000001", ctl);
        end
        cyc();
        i_awready = 1'b0;
        i_wready  = 1'b0;
        i_bvalid  = 1'b0;
    endtask

    task automatic test_skewed_write();
        int pulses;
        logic [5:0] exp_ctl;
        pulses   = 0;
        i_bvalid = 1'b1;
        issue(1'b0, 32'h0000_1236, 2'b01, 1'b0, 64'h0000_0000_0000_BEEF, 64'd0);
        for (int c = 0; c < 8; c++) begin
            cyc();
            if (c == 0) i_valid = 1'b0;
            exp_ctl = {1'b0, c == 0, c <= 3, 1'b0, c == 4, c == 5};
            if (o_ready) pulses++;
            n_tests++;
            if (ctl !== exp_ctl) begin
                n_fail++;
                $display("FAIL skew_cycle%0d: ctl=%b, want %b", c, ctl, exp_ctl);
            end
            if (c == 0) i_awready = 1'b1;
            if (c == 1) i_awready = 1'b0;
            if (c == 3) i_wready  = 1'b1;
            if (c == 4) i_wready  = 1'b0;
        end
        n_tests++;
        if (pulses !== 1) begin
            n_fail++;
            $display("FAIL skew_ready_count: got %0d pulses, want 1", pulses);
        end
        i_bvalid = 1'b0;
    endtask

    task automatic test_read_half_backpressure();
        bit got;
        i_arready = 1'b1;
        i_rvalid  = 1'b0;
        issue(1'b1, 32'h4000_0002, 2'b01, 1'b0, 64'd0, 64'hDEADBEEF_CAFE0000);
        cyc();
        i_valid = 1'b0;
        n_tests++;
        if (ctl !== 6'b100000 || o_arcache !== 4'h0 || o_arsize !== 3'd1) begin
            n_fail++;
            $display("FAIL rd_half_ar: ctl=%b cache=%h size=%0d, want 100000 0 1", ctl, o_arcache, o_arsize);
        end
        for (int k = 0; k < 5; k++) begin
            cyc();
            n_tests++;
            if (ctl !== 6'b000100) begin
                n_fail++;
                $display("FAIL rd_half_wait%0d: ctl=%b, want 000100", k, ctl);
            end
        end
        i_rvalid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            cyc();
            if (o_ready) got = 1'b1;
        end
        n_tests++;
        if (!got || o_rdata !== 64'h0000DEADBEEFCAFE) begin
            n_fail++;
            $display("FAIL rd_half_data: ready_seen=%b rdata=%h, want ready_seen=1 rdata=0000deadbeefcafe", got, o_rdata);
        end
        cyc();
        i_arready = 1'b0;
        i_rvalid  = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_ctl;
        i_arready = 1'b1;
        i_rvalid  = 1'b1;
        issue(1'b1, 32'h0000_1000, 2'b10, 1'b1, 64'd0, 64'h0123456789ABCDEF);
        for (int c = 0; c < 8; c++) begin
            cyc();
            exp_ctl = {c == 0 || c == 4, 1'b0, 1'b0, c == 1 || c == 5, 1'b0, c == 2 || c == 6};
            n_tests++;
            if (ctl !== exp_ctl) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d: ctl=%b, want %b", c, ctl, exp_ctl);
            end
            if (c == 4) begin
                n_tests++;
                if (o_araddr !== 32'h0000_2004) begin
                    n_fail++;
                    $display("FAIL b2b_second_addr: araddr=%h, want 00002004", o_araddr);
                end
                i_valid = 1'b0;
            end
            if (c == 0) issue(1'b1, 32'h0000_2004, 2'b10, 1'b1, 64'd0, 64'h0123456789ABCDEF);
        end
        i_arready = 1'b0;
        i_rvalid  = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit got;
        i_arready = 1'b1;
        i_rvalid  = 1'b0;
        issue(1'b1, 32'h0000_3000, 2'b11, 1'b1, 64'd0, 64'h5555_6666_7777_8888);
        cyc();
        i_valid = 1'b0;
        cyc();
        n_tests++;
        if (ctl !== 6'b000100) begin
            n_fail++;
            $display("FAIL rst_mid_pre: ctl=%b, want 000100", ctl);
        end
        #2 i_rst_n = 1'b0;
        #1;
        n_tests++;
        if (ctl !== 6'b000000 || o_rdata !== 64'd0) begin
            n_fail++;
            $display("FAIL rst_mid_async: ctl=%b rdata=%h, want 000000 0", ctl, o_rdata);
        end
        q_done.delete();
        repeat (2) cyc();
        n_tests++;
        if (ctl !== 6'b000000) begin
            n_fail++;
            $display("FAIL rst_mid_hold: ctl=%b, want 000000", ctl);
        end
        i_rst_n  = 1'b1;
        i_rvalid = 1'b1;
        cyc();
        issue(1'b1, 32'h0000_3008, 2'b11, 1'b0, 64'd0, 64'hA5A5_5A5A_0F0F_F0F0);
        cyc();
        i_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            cyc();
            if (o_ready) got = 1'b1;
        end
        n_tests++;
        if (!got || o_rdata !== 64'hA5A5_5A5A_0F0F_F0F0) begin
            n_fail++;
            $display("FAIL rst_mid_recover: ready_seen=%b rdata=%h, want ready_seen=1 rdata=a5a55a5a0f0ff0f0", got, o_rdata);
        end
        cyc();
        i_arready = 1'b0;
        i_rvalid  = 1'b0;
    endtask

    initial begin
        i_rst_n = 1'b0; i_valid = 1'b0; i_reqtyp = 1'b0; i_addr = '0; i_wdata = '0;
        i_cachable = 1'b0; i_size = 2'b00;
        i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0; i_bresp = 2'b10;
        i_arready = 1'b0; i_rvalid = 1'b0; i_rdata = '0; i_rresp = 2'b11; i_rlast = 1'b0;
        test_reset();
        test_read_dword();
        test_write_byte();
        test_skewed_write();
        test_read_half_backpressure();
        test_back_to_back();
        test_reset_mid();
        repeat (2) cyc();
        n_tests++;
        if (q_ar.size() + q_aw.size() + q_w.size() + q_done.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: ar=%0d aw=%0d w=%0d done=%0d left, want all 0",
                     q_ar.size(), q_aw.size(), q_w.size(), q_done.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uni_axi_bridge.md
UNI_AXI_BRIDGE -- requirements
Module: uni_axi_bridge

Interface
REQ-001 Parameter ADDR_W, default 32, address width on both sides.
REQ-002 Parameter DATA_W, default 64, data width on both sides; only 64 is supported.
REQ-003 Parameter AXI_ID, default 4'd0, constant ID driven on o_awid/o_arid.
REQ-004 The block SHALL use one clock, i_clk, and one asynchronous active-low reset, i_rst_n.
REQ-005 The block SHALL provide these ports (name, direction, width, meaning):
- i_clk, in, 1, clock.
- i_rst_n, in, 1, asynchronous reset, active low.
- uni Slave port (flat): i_valid 1, o_ready 1, i_reqtyp 1 (0=read, 1=write), i_addr ADDR_W, i_wdata 64, o_rdata 64, i_cachable 1, i_size 2 (00=byte, 01=half, 10=word, 11=dword).
- AXI4 AW channel: o_awvalid 1, i_awready 1, o_awaddr ADDR_W, o_awid 4, o_awlen 8, o_awsize 3, o_awburst 2, o_awcache 4.
- AXI4 W channel: o_wvalid 1, i_wready 1, o_wdata 64, o_wstrb 8, o_wlast 1.
- AXI4 B channel: i_bvalid 1, o_bready 1, i_bresp 2.
- AXI4 AR channel: o_arvalid 1, i_arready 1, o_araddr ADDR_W, o_arid 4, o_arlen 8, o_arsize 3, o_arburst 2, o_arcache 4.
- AXI4 R channel: i_rvalid 1, o_rready 1, i_rdata 64, i_rresp 2, i_rlast 1.

Function
REQ-006 The bridge SHALL handle one outstanding single-beat transaction; FSM states are IDLE, RD_A, RD_D, WR_AW, WR_B, DONE.
REQ-007 In IDLE, if i_valid=1, the bridge SHALL latch addr, wdata, size, cachable, and reqtyp, then go to RD_A (reqtyp=0) or WR_AW (reqtyp=1).
REQ-008 RD_A SHALL hold o_arvalid=1 with latched fields until i_arready=1, then go to RD_D.
REQ-009 RD_D SHALL hold o_rready=1; on i_rvalid=1 it SHALL register o_rdata = i_rdata >> (8*addr[2:0]) (zero-filled), then go to DONE.
REQ-010 WR_AW SHALL raise o_awvalid and o_wvalid together, and drop each independently on its own handshake; when both have completed (same or different cycles) it SHALL go to WR_B.
REQ-011 WR_B SHALL hold o_bready=1 until i_bvalid=1, then go to DONE.
REQ-012 DONE SHALL assert o_ready=1 for exactly one cycle, then return to IDLE; i_valid SHALL NOT be sampled in DONE.
REQ-013 o_ready SHALL be 0 in all states except DONE.
REQ-014 Fixed fields: awlen/arlen=0, awburst/arburst=2'b01, wlast=1, awsize/arsize={1'b0,size}, awcache/arcache = cachable ? 4'b1111 : 4'b0000.
REQ-015 o_wdata SHALL equal wdata << (8*addr[2:0]).
REQ-016 o_wstrb SHALL equal (size mask 8'h01/03/0F/FF) << addr[2:0].
REQ-017 Addresses SHALL be forwarded unmodified.
REQ-018 Natural alignment is the requester's obligation; the bridge performs no alignment check.
REQ-019 i_rresp, i_bresp, and i_rlast SHALL be ignored.
REQ-020 Minimum latency SHALL be 4 cycles (valid sampled, then A, then D/B, then DONE) when slaves respond immediately.
REQ-021 The AXI valid signals SHALL NOT depend combinationally on any AXI ready input.
REQ-022 The AXI valid signals SHALL NOT drop before their handshake completes.
REQ-023 The AXI valid signals and o_ready SHALL be registered outputs.

Reset
REQ-024 While i_rst_n=0, the FSM SHALL be in IDLE.
REQ-025 While i_rst_n=0, all valid/ready outputs, o_rdata, and the latched fields SHALL be 0.
REQ-026 Assertion of i_rst_n mid-transaction SHALL abort the transaction immediately (asynchronously), with no o_ready pulse.

Verification
REQ-027 Read dword: addr=0x8000_0008, size=11, AR/R ready immediately, rdata=0x1122334455667788 -> araddr=0x8000_0008, arsize=3; o_ready one cycle, 4 cycles after valid sampled; o_rdata=0x1122334455667788.
REQ-028 Write byte: addr=0x8000_0005, size=00, wdata=0xAB -> wstrb=8'h20, wdata=0x0000_AB00_0000_0000, awsize=0; o_ready after B.
REQ-029 Skewed write handshake: i_awready in cycle 1, i_wready 3 cycles later -> awvalid drops after its handshake, wvalid stays high until its own; B is not awaited before both complete; exactly one o_ready.
REQ-030 Read half-word with R backpressure: addr=...2, size=01, i_rvalid delayed 5 cycles, i_rdata=0xDEADBEEF_CAFE0000 -> o_rdata=0x0000DEADBEEFCAFE; arcache=0 when cachable=0.
REQ-031 Back-to-back: i_valid held high across two requests -> second request captured only in the IDLE cycle after DONE; no duplicate issue.
REQ-032 Reset during RD_D -> arvalid/rready/o_ready=0 immediately; a subsequent read completes normally.
